// File: rtl/s2p.sv
// Serial-to-parallel deserializer: collects N qualified serial bits into a word
// and presents it on a double-buffered parallel valid/ready port.
module s2p #(
    parameter int N         = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         s_data,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [N-1:0] p_data,
    output logic         p_valid,
    input  logic         p_ready
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  sr_q, sr_d;
    logic          full_q, full_d;
    logic [N-1:0]  p_data_q, p_data_d;
    logic          p_valid_q, p_valid_d;

    logic [N-1:0]  word;
    logic          xfer;
    logic          complete;
    logic          out_free;
    logic          drain;

    generate
        if (LSB_FIRST) begin : g_lsb
            assign word = {s_data, sr_q[N-1:1]};
        end else begin : g_msb
            assign word = {sr_q[N-2:0], s_data};
        end
    endgenerate

    // s_ready depends only on the full flop, so no combinational path reaches it.
    assign s_ready  = !full_q;
    assign xfer     = s_valid && !full_q;
    assign complete = xfer && (cnt_q == CNT_LAST);
    assign out_free = !p_valid_q || p_ready;
    assign drain    = p_valid_q && p_ready;

    always_comb begin
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        full_d    = full_q;
        p_data_d  = p_data_q;
        p_valid_d = p_valid_q;

        if (xfer) begin
            sr_d  = word;
            cnt_d = complete ? '0 : cnt_q + 1'b1;
        end

        if (full_q) begin
            // The held word lives in sr; it moves out as soon as the output drains.
            if (drain) begin
                p_data_d  = sr_q;
                p_valid_d = 1'b1;
                full_d    = 1'b0;
            end
        end else if (complete) begin
            if (out_free) begin
                p_data_d  = word;
                p_valid_d = 1'b1;
            end else begin
                full_d = 1'b1;
            end
        end else if (drain) begin
            p_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q     <= '0;
            sr_q      <= '0;
            full_q    <= 1'b0;
            p_data_q  <= '0;
            p_valid_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
            full_q    <= full_d;
            p_data_q  <= p_data_d;
            p_valid_q <= p_valid_d;
        end
    end

    assign p_data  = p_data_q;
    assign p_valid = p_valid_q;

endmodule

// File: doc/s2p.md
Name: s2p

Overview:
- Serial-to-parallel deserializer. It is the receive-side neighbour of p2s: it consumes the 1-bit valid/ready stream that p2s produces and rebuilds N-bit words.
- Words are presented on a parallel valid/ready output port.
- It is double-buffered: a shift register collects the next word while a completed word waits in the output register. Sustained throughput is one word per N accepted bits.

Parameters:
- N, 8, word width in bits; legal values N >= 2.
- LSB_FIRST, 1, bit order: 1 = first serial bit lands in p_data[0]; 0 = first serial bit lands in p_data[N-1].

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rstn  input  1  asynchronous active-low reset.
- s_data  input  1  serial data bit.
- s_valid  input  1  s_data is valid this cycle.
- s_ready  output  1  block accepts a bit this cycle.
- p_data  output  N  assembled parallel word.
- p_valid  output  1  p_data holds a complete word.
- p_ready  input  1  downstream accepts p_data this cycle.

Behaviour:
- Reset (rstn low, asynchronous assert):
  - p_valid=0, p_data=0, s_ready=1.
  - Bit counter cnt=0, shift register sr=0, internal flag full=0.
  - Reset release takes effect synchronously, on the first rising edge with rstn high.
- Bit transfer occurs on an edge where s_valid && s_ready; only such edges shift a bit. s_valid low cycles are ignored, and cnt and sr hold.
- Shift:
  - LSB_FIRST=1: sr <= {s_data, sr[N-1:1]}.
  - LSB_FIRST=0: sr <= {sr[N-2:0], s_data}.
- cnt counts 0..N-1 and wraps to 0 on the bit transfer that completes a word (cnt==N-1).
- The word-complete word is sr with the incoming bit merged, computed combinationally.
- Output register free this edge means !p_valid || p_ready.
- On word-complete, if the output register is free: p_data <= word, p_valid <= 1.
- On word-complete, if the output register is not free: word is stored in sr, full <= 1.
- While full=1:
  - s_ready=0, so no bit transfers occur.
  - On the edge where p_valid && p_ready: p_data <= sr, p_valid stays 1, full <= 0.
  - s_ready returns to 1 in the following cycle.
- p_valid falls on an edge with p_valid && p_ready when no new word completes and full=0 that cycle.
- Output stability: while p_valid && !p_ready, p_data and p_valid hold.
- s_ready is driven only from the full register; there is no combinational path from p_ready or s_valid to s_ready.
- Latency: if the last bit of a word is accepted at edge k, p_valid=1 with that word from edge k.
- Simultaneous events:
  - Word-complete on the same edge as an output handshake: the new word replaces the drained one, p_valid stays 1, no bubble.
  - p_ready high with p_valid low: no effect.
- Reset mid-word: partially collected bits and any held word are discarded; the next word starts at bit 0.
- No framing, parity or error detection. Word alignment is defined solely by the bit count since reset.

Test Plan:
1. Assert rstn=0 mid-simulation -> immediately p_valid=0, p_data=0, s_ready=1. After release, hold s_valid=0 for 5 cycles -> no p_valid, cnt unchanged.
2. N=8, LSB_FIRST=1, p_ready=1. Send 8'd62 LSB first (bits 0,1,1,1,1,1,0,0) on consecutive cycles -> p_valid high for exactly one cycle after the 8th bit, with p_data=8'h3E.
3. Send 8'd52 with s_valid low on alternate cycles -> only qualified bits count, p_data=8'h34 after the 8th valid bit. Send four words back to back with s_valid=1, p_ready=1 -> one p_valid pulse every 8 cycles and s_ready never drops.
4. Backpressure:
   - Set p_ready=0 and send 8'h3E then 8'hA5 -> p_data=8'h3E holds with p_valid=1.
   - After the 8th bit of 8'hA5, s_ready=0 and s_data changes are ignored.
   - Raise p_ready for one cycle -> 8'h3E handshakes, next cycle p_data=8'hA5 with p_valid=1, then s_ready=1.
5. Send 3 bits, pulse rstn low, then send 8'd7 -> p_data=8'h07 with no residue from the partial word.
6. Instance with LSB_FIRST=0: send 8'h3E MSB first (0,0,1,1,1,1,1,0) -> p_data=8'h3E.
